// File: rtl/weight_loader_if.sv
// ============================================================================
// Module      : weight_loader_if
// Description : Stream input (valid/ready/data) and weight-memory write port
//               (wen/wadd/win) of the weight loader, bundled as one interface.
//               The master modport is the loader side.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface weight_loader_if #(
  parameter int dataWidth    = 16,
  parameter int addressWidth = 5,
  parameter int numNeuron    = 10
);
  logic                    s_valid;
  logic [dataWidth-1:0]    s_data;
  logic                    s_ready;
  logic [numNeuron-1:0]    wen;
  logic [addressWidth-1:0] wadd;
  logic [dataWidth-1:0]    win;

  modport master (
    input  s_valid, s_data,
    output s_ready, wen, wadd, win
  );

  modport slave (
    output s_valid, s_data,
    input  s_ready, wen, wadd, win
  );
endinterface

`default_nettype wire

// File: rtl/weight_loader.sv
// ============================================================================
// Module      : weight_loader
// Description : Splits a flat stream of weight words across numNeuron weight
//               memories, neuron-major, driving their shared write port.
//               Optional macro WLOAD_CHECKSUM_EN adds a wrap-around sum of the
//               accepted words that is compared against exp_sum at the end.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module weight_loader #(
  parameter int numWeight    = 30,
  parameter int numNeuron    = 10,
  parameter int dataWidth    = 16,
  parameter int addressWidth = $clog2(numWeight),
  parameter int neuronWidth  = $clog2(numNeuron)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  weight_loader_if.master      wl,
  output logic                 busy,
  output logic                 done
`ifdef WLOAD_CHECKSUM_EN
  ,
  input  logic [dataWidth-1:0] exp_sum,
  output logic                 sum_err
`endif
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [addressWidth-1:0] LAST_WIDX = addressWidth'(numWeight - 1);
  localparam logic [neuronWidth-1:0]  LAST_NIDX = neuronWidth'(numNeuron - 1);
  localparam logic [numNeuron-1:0]    NEURON0   = numNeuron'(1);

  state_t                  state;
  state_t                  state_next;
  logic [addressWidth-1:0] widx;
  logic [neuronWidth-1:0]  nidx;
  logic                    accept;
  logic                    widx_last;
  logic                    last_word;
  logic                    load_start;

  // Accept is derived from state rather than s_ready to keep it free of the FSM comb path.
  assign accept     = wl.s_valid & (state == LOAD);
  assign widx_last  = (widx == LAST_WIDX);
  assign last_word  = widx_last & (nidx == LAST_NIDX);
  assign load_start = (state == IDLE) & start;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; the final accept moves to FLUSH so s_ready drops next cycle.
  always_comb begin
    state_next = state;
    wl.s_ready = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = LOAD;
      end
      LOAD: begin
        wl.s_ready = 1'b1;
        busy       = 1'b1;
        if (wl.s_valid && last_word) state_next = FLUSH;
      end
      FLUSH: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Word and neuron counters: cleared on start, advanced on every accepted word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      widx <= '0;
      nidx <= '0;
    end else if (load_start) begin
      widx <= '0;
      nidx <= '0;
    end else if (accept) begin
      if (widx_last) begin
        widx <= '0;
        nidx <= nidx + 1'b1;
      end else begin
        widx <= widx + 1'b1;
      end
    end
  end

  // Registered write port: one-cycle enable per accept, address/data hold between writes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wl.wen  <= '0;
      wl.wadd <= '0;
      wl.win  <= '0;
    end else begin
      wl.wen <= '0;
      if (accept) begin
        wl.wen  <= NEURON0 << nidx;
        wl.wadd <= widx;
        wl.win  <= wl.s_data;
      end
    end
  end

`ifdef WLOAD_CHECKSUM_EN
  logic [dataWidth-1:0] sum;

  // Running wrap-around sum of accepted words; verdict latched while in DONE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sum     <= '0;
      sum_err <= 1'b0;
    end else if (load_start) begin
      sum     <= '0;
      sum_err <= 1'b0;
    end else begin
      if (accept) sum <= sum + wl.s_data;
      if (state == DONE) sum_err <= (sum != exp_sum);
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_weight_loader.sv
// ============================================================================
// Module      : tb_weight_loader
// Description : Self-checking bench for weight_loader. A 4x2 instance runs
//               cycle-accurate vector tables plus reset/checksum sequences;
//               a 30x10 instance runs a 300-word load with a scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_weight_loader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   n_vec = 0;
  int   n_bad = 0;

  // 4 weights x 2 neurons instance
  logic sm_start, sm_busy, sm_done;
  weight_loader_if #(.dataWidth(16), .addressWidth(2), .numNeuron(2)) sm_if ();

  // default 30 x 10 instance
  logic df_start, df_busy, df_done;
  weight_loader_if #(.dataWidth(16), .addressWidth(5), .numNeuron(10)) df_if ();

`ifdef WLOAD_CHECKSUM_EN
  logic [15:0] sm_exp, df_exp;
  logic        sm_err, df_err;
`endif

  weight_loader #(.numWeight(4), .numNeuron(2), .dataWidth(16)) dut_small (
    .clk(clk), .rst(rst), .start(sm_start), .wl(sm_if),
    .busy(sm_busy), .done(sm_done)
`ifdef WLOAD_CHECKSUM_EN
    , .exp_sum(sm_exp), .sum_err(sm_err)
`endif
  );

  weight_loader #(.numWeight(30), .numNeuron(10), .dataWidth(16)) dut_default (
    .clk(clk), .rst(rst), .start(df_start), .wl(df_if),
    .busy(df_busy), .done(df_done)
`ifdef WLOAD_CHECKSUM_EN
    , .exp_sum(df_exp), .sum_err(df_err)
`endif
  );

  typedef struct packed {
    logic        st;
    logic        v;
    logic [15:0] d;
    logic        rdy;
    logic        bsy;
    logic        dn;
    logic [1:0]  wn;
    logic [1:0]  wa;
    logic [15:0] wi;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push(input logic st, input logic v, input logic [15:0] d,
                      input logic rdy, input logic bsy, input logic dn,
                      input logic [1:0] wn, input logic [1:0] wa, input logic [15:0] wi);
    vec_t t;
    t.st = st; t.v = v; t.d = d; t.rdy = rdy; t.bsy = bsy; t.dn = dn;
    t.wn = wn; t.wa = wa; t.wi = wi;
    vecs.push_back(t);
  endtask

  // Back-to-back load of words 1..8; start re-pulsed on cycle start_at (ignored while busy).
  task automatic add_basic(input int start_at, input logic [1:0] pa, input logic [15:0] pw);
    push(1'b1,              1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, pa,   pw);
    push(start_at == 1,     1'b1, 16'h0001, 1'b1, 1'b1, 1'b0, 2'b00, pa,   pw);
    push(start_at == 2,     1'b1, 16'h0002, 1'b1, 1'b1, 1'b0, 2'b01, 2'd0, 16'h0001);
    push(start_at == 3,     1'b1, 16'h0003, 1'b1, 1'b1, 1'b0, 2'b01, 2'd1, 16'h0002);
    push(start_at == 4,     1'b1, 16'h0004, 1'b1, 1'b1, 1'b0, 2'b01, 2'd2, 16'h0003);
    push(start_at == 5,     1'b1, 16'h0005, 1'b1, 1'b1, 1'b0, 2'b01, 2'd3, 16'h0004);
    push(start_at == 6,     1'b1, 16'h0006, 1'b1, 1'b1, 1'b0, 2'b10, 2'd0, 16'h0005);
    push(start_at == 7,     1'b1, 16'h0007, 1'b1, 1'b1, 1'b0, 2'b10, 2'd1, 16'h0006);
    push(start_at == 8,     1'b1, 16'h0008, 1'b1, 1'b1, 1'b0, 2'b10, 2'd2, 16'h0007);
    push(1'b0,              1'b1, 16'hBEEF, 1'b0, 1'b1, 1'b0, 2'b10, 2'd3, 16'h0008);
    push(1'b0,              1'b1, 16'hCAFE, 1'b0, 1'b0, 1'b1, 2'b00, 2'd3, 16'h0008);
    push(1'b0,              1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'd3, 16'h0008);
  endtask

  // Valid pattern 1,0,0 per word; garbage on the bubble cycles.
  task automatic add_bubbles();
    logic [1:0]  la;
    logic [15:0] lw;
    logic [1:0]  oh;
    la = 2'd3;
    lw = 16'h0008;
    push(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, la, lw);
    for (int k = 1; k <= 8; k++) begin
      push(1'b0, 1'b1, 16'(k), 1'b1, 1'b1, 1'b0, 2'b00, la, lw);
      la = 2'((k - 1) % 4);
      lw = 16'(k);
      oh = (k <= 4) ? 2'b01 : 2'b10;
      if (k < 8) begin
        push(1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b0, oh,    la, lw);
        push(1'b0, 1'b0, 16'hDEAD, 1'b1, 1'b1, 1'b0, 2'b00, la, lw);
      end else begin
        push(1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b1, 1'b0, oh,    la, lw);
        push(1'b0, 1'b0, 16'hDEAD, 1'b0, 1'b0, 1'b1, 2'b00, la, lw);
      end
    end
    push(1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 2'b00, 2'd3, 16'h0008);
  endtask

  task automatic run_range(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(posedge clk); #1;
      sm_start      = vecs[i].st;
      sm_if.s_valid = vecs[i].v;
      sm_if.s_data  = vecs[i].d;
      @(negedge clk);
      check($sformatf("vec%0d", i),
            64'({sm_if.s_ready, sm_busy, sm_done, sm_if.wen, sm_if.wadd, sm_if.win}),
            64'({vecs[i].rdy, vecs[i].bsy, vecs[i].dn, vecs[i].wn, vecs[i].wa, vecs[i].wi}));
    end
  endtask

`ifdef WLOAD_CHECKSUM_EN
  task automatic sm_start_pulse();
    @(posedge clk); #1 sm_start = 1'b1;
    @(posedge clk); #1 sm_start = 1'b0;
  endtask

  task automatic sm_feed(input logic [15:0] base);
    bit seen;
    sm_if.s_valid = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      sm_if.s_data = base + 16'(k);
      @(posedge clk); #1;
    end
    sm_if.s_valid = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge clk);
      if (sm_done) seen = 1'b1;
    end
    if (!seen) check("ck_done_timeout", 64'(seen), 64'd1);
  endtask
`endif

  initial begin
    int seg_a, seg_b, seg_c, seg_d, seg_end;
    bit seen;
    logic [30:0] exp_q[$];
    int sent, writes, dones, extra, tail;
    bit pend_rdy;

    rst = 1'b1;
    sm_start = 1'b0; sm_if.s_valid = 1'b0; sm_if.s_data = '0;
    df_start = 1'b0; df_if.s_valid = 1'b0; df_if.s_data = '0;
`ifdef WLOAD_CHECKSUM_EN
    sm_exp = 16'h0024;
    df_exp = 16'h0000;
`endif

    seg_a = vecs.size(); add_basic(-1, 2'd0, 16'h0000);
    seg_b = vecs.size(); add_basic(4, 2'd3, 16'h0008);
    seg_c = vecs.size(); add_bubbles();
    seg_d = vecs.size(); add_basic(-1, 2'd0, 16'h0000);
    seg_end = vecs.size();

    // reset state of both instances
    #2;
    check("rst_small", 64'({sm_if.s_ready, sm_busy, sm_done, sm_if.wen, sm_if.wadd, sm_if.win}), 64'd0);
    check("rst_default", 64'({df_if.s_ready, df_busy, df_done, df_if.wen, df_if.wadd, df_if.win}), 64'd0);
`ifdef WLOAD_CHECKSUM_EN
    check("rst_sum_err", 64'(sm_err), 64'd0);
`endif
    @(negedge clk); @(negedge clk);
    rst = 1'b0;

    run_range(seg_a, seg_b);
    run_range(seg_b, seg_c);
    run_range(seg_c, seg_d);

    // asynchronous reset in the cycle the 5th word is being written
    @(posedge clk); #1 sm_start = 1'b1;
    @(posedge clk); #1 sm_start = 1'b0; sm_if.s_valid = 1'b1; sm_if.s_data = 16'h0101;
    for (int k = 2; k <= 5; k++) begin
      @(posedge clk); #1 sm_if.s_data = 16'h0100 + 16'(k);
    end
    @(posedge clk); #1 sm_if.s_valid = 1'b0;
    #1 check("pre_rst_write5", 64'({sm_if.wen, sm_if.wadd, sm_if.win}), 64'({2'b10, 2'd0, 16'h0105}));
    rst = 1'b1;
    #1 check("async_rst_outputs",
             64'({sm_if.s_ready, sm_busy, sm_done, sm_if.wen, sm_if.wadd, sm_if.win}), 64'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (sm_done || sm_busy) seen = 1'b1;
    end
    check("rst_no_done", 64'(seen), 64'd0);

    run_range(seg_d, seg_end);

`ifdef WLOAD_CHECKSUM_EN
    sm_exp = 16'h0024;
    sm_start_pulse();
    sm_feed(16'h0000);
    @(negedge clk);
    check("ck_match", 64'(sm_err), 64'd0);
    sm_exp = 16'h0025;
    sm_start_pulse();
    sm_feed(16'h0000);
    @(negedge clk);
    check("ck_mismatch", 64'(sm_err), 64'd1);
    repeat (2) @(negedge clk);
    check("ck_held", 64'(sm_err), 64'd1);
    sm_start_pulse();
    @(negedge clk);
    check("ck_clear_on_start", 64'(sm_err), 64'd0);
    sm_exp = 16'h0024;
    sm_feed(16'h0000);
`endif

    // default geometry: 300 random words with random bubbles
    sent = 0; writes = 0; dones = 0; extra = 0; tail = 0; pend_rdy = 1'b0;
    @(posedge clk); #1 df_start = 1'b1;
    @(posedge clk); #1 df_start = 1'b0;
    for (int cyc = 0; cyc < 1200 && tail < 4; cyc++) begin
      df_if.s_valid = (sent >= 300) || ($urandom_range(0, 3) != 0);
      df_if.s_data  = 16'($urandom);
      @(negedge clk);
      if (pend_rdy) begin
        check("df_ready_after_300", 64'(df_if.s_ready), 64'd0);
        pend_rdy = 1'b0;
      end
      if (df_if.wen != '0) begin
        writes++;
        if (exp_q.size() == 0) check("df_unexpected_write", 64'(df_if.wen), 64'd0);
        else check($sformatf("df_write%0d", writes), 64'({df_if.wen, df_if.wadd, df_if.win}),
                   64'(exp_q.pop_front()));
      end
      if (df_if.s_valid && df_if.s_ready) begin
        if (sent < 300) begin
          exp_q.push_back({10'd1 << (sent / 30), 5'(sent % 30), df_if.s_data});
          sent++;
          if (sent == 300) pend_rdy = 1'b1;
        end else begin
          extra++;
        end
      end
      if (df_done) dones++;
      if (dones > 0) tail++;
      @(posedge clk); #1;
    end
    df_if.s_valid = 1'b0;
    check("df_write_count", 64'(writes), 64'd300);
    check("df_done_count", 64'(dones), 64'd1);
    check("df_extra_accepts", 64'(extra), 64'd0);
    check("df_busy_end", 64'(df_busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
